mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates I/D L1 misses onto one external memory port; grant lands one cycle after cs is sampled.
// No backpressure: a busy owner waits indefinitely for mem_ack, with one RESP cycle before re-arbitration.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_cs,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    // On a tie D wins unless it was the previous winner.
    pick_d       = d_cs && (!i_cs || (last_grant_q == GNT_I));

    case (state_q)
      IDLE: begin
        if (i_cs || d_cs) begin
          state_d      = pick_d ? BUSY_D : BUSY_I;
          last_grant_d = pick_d ? GNT_D : GNT_I;
          mem_cs_d     = 1'b1;
          mem_we_d     = pick_d ? d_we : i_we;
          mem_addr_d   = pick_d ? d_addr : i_addr;
          mem_wdata_d  = pick_d ? d_wdata : i_wdata;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          state_d  = RESP;
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          if (!mem_we_q) begin
            if (state_q == BUSY_D) d_rdata_d = mem_rdata;
            else                   i_rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_grant still names the owner while in RESP.
  assign i_ack     = (state_q == RESP) && (last_grant_q == GNT_I);
  assign d_ack     = (state_q == RESP) && (last_grant_q == GNT_D);
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
